// File: rtl/tlc_phase_sequencer.sv
// Two-road traffic light phase sequencer with pedestrian walk phase.
// A free-running prescaler yields a 1-s enable; all state lives on clk_osc.
module tlc_phase_sequencer #(
  parameter int TICK_DIV  = 50000000,
  parameter int GREEN_A_S = 10,
  parameter int GREEN_B_S = 6,
  parameter int YELLOW_S  = 3,
  parameter int RED_ALL_S = 1,
  parameter int PED_S     = 5
) (
  input  logic       clk_osc,
  input  logic       RESET,
  input  logic       car_b,
  input  logic       ped_req,
  output logic [2:0] lights_a,
  output logic [2:0] lights_b,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] state,
  output logic [3:0] sec_left
);

  localparam int              CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [3:0]      T_GA    = 4'(GREEN_A_S);
  localparam logic [3:0]      T_GB    = 4'(GREEN_B_S);
  localparam logic [3:0]      T_Y     = 4'(YELLOW_S);
  localparam logic [3:0]      T_RED   = 4'(RED_ALL_S);
  localparam logic [3:0]      T_PED   = 4'(PED_S);
  localparam logic [2:0]      LAMP_R  = 3'b100;
  localparam logic [2:0]      LAMP_Y  = 3'b010;
  localparam logic [2:0]      LAMP_G  = 3'b001;

  typedef enum logic [2:0] {
    ALLRED_A = 3'd0,
    A_GREEN  = 3'd1,
    A_YELLOW = 3'd2,
    ALLRED_B = 3'd3,
    PED_WALK = 3'd4,
    B_GREEN  = 3'd5,
    B_YELLOW = 3'd6
  } phase_e;

  generate
    if (TICK_DIV < 1 ||
        GREEN_A_S < 1 || GREEN_A_S > 15 || GREEN_B_S < 1 || GREEN_B_S > 15 ||
        YELLOW_S  < 1 || YELLOW_S  > 15 || RED_ALL_S < 1 || RED_ALL_S > 15 ||
        PED_S     < 1 || PED_S     > 15) begin : g_param_check
      $error("tlc_phase_sequencer: phase durations must be 1..15 and TICK_DIV >= 1");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick;
  logic             expire;
  phase_e           phase_q;
  logic [3:0]       timer_q;
  logic             ped_pending_q;
  logic             ped_ack_q;

  assign tick   = (cnt_q == CNT_MAX);
  assign cnt_d  = tick ? '0 : cnt_q + 1'b1;
  assign expire = tick && (timer_q <= 4'd1);

  always_ff @(posedge clk_osc) begin
    if (RESET) begin
      cnt_q         <= '0;
      phase_q       <= ALLRED_A;
      timer_q       <= T_RED;
      ped_pending_q <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ped_ack_q <= 1'b0;
      // Requests during the walk are absorbed; the entry edge clears below.
      if (ped_req && phase_q != PED_WALK) ped_pending_q <= 1'b1;
      if (tick && timer_q > 4'd1) timer_q <= timer_q - 4'd1;
      case (phase_q)
        ALLRED_A: if (expire) begin
          phase_q <= A_GREEN;
          timer_q <= T_GA;
        end
        A_GREEN: if (expire) begin
          if (car_b || ped_pending_q) begin
            phase_q <= A_YELLOW;
            timer_q <= T_Y;
          end else begin
            timer_q <= T_GA;
          end
        end
        A_YELLOW: if (expire) begin
          phase_q <= ALLRED_B;
          timer_q <= T_RED;
        end
        ALLRED_B: if (expire) begin
          if (ped_pending_q) begin
            phase_q       <= PED_WALK;
            timer_q       <= T_PED;
            ped_ack_q     <= 1'b1;
            ped_pending_q <= 1'b0;
          end else begin
            phase_q <= B_GREEN;
            timer_q <= T_GB;
          end
        end
        PED_WALK: if (expire) begin
          if (car_b) begin
            phase_q <= B_GREEN;
            timer_q <= T_GB;
          end else begin
            phase_q <= ALLRED_A;
            timer_q <= T_RED;
          end
        end
        B_GREEN: if (expire) begin
          phase_q <= B_YELLOW;
          timer_q <= T_Y;
        end
        B_YELLOW: if (expire) begin
          phase_q <= ALLRED_A;
          timer_q <= T_RED;
        end
        default: begin
          phase_q <= ALLRED_A;
          timer_q <= T_RED;
        end
      endcase
    end
  end

  // Lamps decode straight from the phase register; code 7 falls to all-red.
  always_comb begin
    lights_a = LAMP_R;
    lights_b = LAMP_R;
    walk     = 1'b0;
    case (phase_q)
      A_GREEN:  lights_a = LAMP_G;
      A_YELLOW: lights_a = LAMP_Y;
      B_GREEN:  lights_b = LAMP_G;
      B_YELLOW: lights_b = LAMP_Y;
      PED_WALK: walk     = 1'b1;
      default:  ;
    endcase
  end

  assign state    = phase_q;
  assign sec_left = timer_q;
  assign ped_ack  = ped_ack_q;

endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// Self-checking bench for tlc_phase_sequencer with a cycle-count reference model.
module tb_tlc_phase_sequencer;

  localparam int TD = 4;
  localparam int GA = 5;
  localparam int GB = 3;
  localparam int YL = 2;
  localparam int RA = 1;
  localparam int PW = 3;

  logic       clk_osc = 1'b0;
  logic       RESET   = 1'b1;
  logic       car_b   = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] lights_a;
  logic [2:0] lights_b;
  logic       walk;
  logic       ped_ack;
  logic [2:0] state;
  logic [3:0] sec_left;
  logic [14:0] obs_vec;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase number, cycles spent in it, pending flag, ack flag.
  int m_phase   = 0;
  int m_elapsed = 0;
  bit m_pending = 1'b0;
  bit m_ack     = 1'b0;

  always #5 clk_osc = ~clk_osc;

  tlc_phase_sequencer #(
    .TICK_DIV(TD), .GREEN_A_S(GA), .GREEN_B_S(GB),
    .YELLOW_S(YL), .RED_ALL_S(RA), .PED_S(PW)
  ) dut (
    .clk_osc(clk_osc), .RESET(RESET), .car_b(car_b), .ped_req(ped_req),
    .lights_a(lights_a), .lights_b(lights_b), .walk(walk), .ped_ack(ped_ack),
    .state(state), .sec_left(sec_left)
  );

  assign obs_vec = {state, sec_left, lights_a, lights_b, walk, ped_ack};

  function automatic int dur(input int p);
    int d;
    case (p)
      1:       d = GA;
      2, 6:    d = YL;
      4:       d = PW;
      5:       d = GB;
      default: d = RA;
    endcase
    return d;
  endfunction

  function automatic logic [14:0] exp_vec();
    logic [2:0] la;
    logic [2:0] lb;
    logic       w;
    int         sec;
    la = 3'b100;
    lb = 3'b100;
    w  = 1'b0;
    case (m_phase)
      1:       la = 3'b001;
      2:       la = 3'b010;
      4:       w  = 1'b1;
      5:       lb = 3'b001;
      6:       lb = 3'b010;
      default: ;
    endcase
    sec = dur(m_phase) - m_elapsed / TD;
    return {m_phase[2:0], sec[3:0], la, lb, w, m_ack};
  endfunction

  // One clock edge: the model sees the inputs present at that edge.
  task automatic advance();
    bit nxt_pending;
    @(posedge clk_osc);
    if (RESET) begin
      m_phase   = 0;
      m_elapsed = 0;
      m_pending = 1'b0;
      m_ack     = 1'b0;
    end else begin
      m_ack       = 1'b0;
      nxt_pending = m_pending;
      if (ped_req && m_phase != 4) nxt_pending = 1'b1;
      if (m_elapsed == dur(m_phase) * TD - 1) begin
        m_elapsed = 0;
        case (m_phase)
          0: m_phase = 1;
          1: m_phase = (car_b || m_pending) ? 2 : 1;
          2: m_phase = 3;
          3: begin
            if (m_pending) begin
              m_phase     = 4;
              m_ack       = 1'b1;
              nxt_pending = 1'b0;
            end else begin
              m_phase = 5;
            end
          end
          4: m_phase = car_b ? 5 : 0;
          5: m_phase = 6;
          default: m_phase = 0;
        endcase
      end else begin
        m_elapsed++;
      end
      m_pending = nxt_pending;
    end
    #1;
  endtask

  task automatic run_until(input int s, input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      if (state == 3'(s)) hit = 1'b1;
      else advance();
    end
    if (state == 3'(s)) hit = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    advance();
    advance();
    n_checks++;
    if (obs_vec !== 15'b000_0001_100_100_0_0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", obs_vec, 15'b000_0001_100_100_0_0);
    end
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      advance();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_release cyc%0d: got %h want %h", i, obs_vec, exp_vec());
      end
    end
    n_checks++;
    if (state !== 3'd1 || lights_a !== 3'b001 || sec_left !== 4'd5) begin
      n_fail++;
      $display("FAIL first_green: got state=%0d la=%b sec=%0d want 1/001/5", state, lights_a, sec_left);
    end
  endtask

  task automatic test_green_extension();
    car_b   = 1'b0;
    ped_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      advance();
      n_checks++;
      if (obs_vec !== exp_vec() || lights_a !== 3'b001) begin
        n_fail++;
        $display("FAIL green_ext cyc%0d: got %h want %h", i, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_car_cycle();
    int exp_ph  [6] = '{2, 3, 5, 6, 0, 1};
    int exp_len [6] = '{8, 4, 12, 8, 4, 20};
    int len;
    bit hit;
    car_b = 1'b1;
    run_until(2, 100, hit);
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL car_to_yellow: got state=%0d want 2", state);
    end
    for (int k = 0; k < 6; k++) begin
      len = 0;
      while (state == 3'(exp_ph[k]) && len < 100) begin
        advance();
        len++;
        n_checks++;
        if (obs_vec !== exp_vec()) begin
          n_fail++;
          $display("FAIL car_cycle ph%0d: got %h want %h", exp_ph[k], obs_vec, exp_vec());
        end
      end
      n_checks++;
      if (len != exp_len[k]) begin
        n_fail++;
        $display("FAIL car_len ph%0d: got %0d cycles want %0d", exp_ph[k], len, exp_len[k]);
      end
    end
    car_b = 1'b0;
  endtask

  task automatic test_ped_walk();
    bit hit;
    int len;
    int acks;
    int bad;
    car_b = 1'b0;
    run_until(1, 100, hit);
    for (int i = 0; i < 3; i++) advance();
    ped_req = 1'b1;
    advance();
    ped_req = 1'b0;
    run_until(4, 200, hit);
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL ped_reach_walk: got state=%0d want 4", state);
    end
    len  = 0;
    acks = 0;
    while (state == 3'd4 && len < 100) begin
      if (ped_ack) acks++;
      n_checks++;
      if (obs_vec !== exp_vec() || walk !== 1'b1) begin
        n_fail++;
        $display("FAIL ped_walk cyc%0d: got %h want %h", len, obs_vec, exp_vec());
      end
      ped_req = (len == 5);
      advance();
      len++;
    end
    ped_req = 1'b0;
    n_checks++;
    if (len != 12 || acks != 1 || state !== 3'd0) begin
      n_fail++;
      $display("FAIL ped_walk_len: got len=%0d acks=%0d next=%0d want 12/1/0", len, acks, state);
    end
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      advance();
      if (state == 3'd4 || state == 3'd2) bad++;
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL ped_after cyc%0d: got %h want %h", i, obs_vec, exp_vec());
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ped_reserved: got %0d cycles in yellow/walk want 0", bad);
    end
  endtask

  task automatic test_ped_and_car();
    int exp_seq [6] = '{2, 3, 4, 5, 6, 0};
    int seq [6];
    int n;
    logic [2:0] prev;
    bit hit;
    run_until(1, 100, hit);
    car_b   = 1'b1;
    ped_req = 1'b1;
    advance();
    ped_req = 1'b0;
    n    = 0;
    prev = state;
    for (int i = 0; i < 300 && n < 6; i++) begin
      advance();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL ped_car cyc%0d: got %h want %h", i, obs_vec, exp_vec());
      end
      if (state != prev) begin
        seq[n] = int'(state);
        n++;
        prev = state;
      end
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (k >= n || seq[k] != exp_seq[k]) begin
        n_fail++;
        $display("FAIL ped_car_order step%0d: got %0d want %0d", k, (k < n) ? seq[k] : -1, exp_seq[k]);
      end
    end
    car_b = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit hit;
    car_b = 1'b1;
    run_until(5, 300, hit);
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL rst_reach_bgreen: got state=%0d want 5", state);
    end
    ped_req = 1'b1;
    advance();
    ped_req = 1'b0;
    advance();
    RESET = 1'b1;
    ped_req = 1'b1;
    advance();
    RESET   = 1'b0;
    ped_req = 1'b0;
    car_b   = 1'b0;
    n_checks++;
    if (obs_vec !== 15'b000_0001_100_100_0_0 || obs_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL mid_reset: got %h want %h", obs_vec, 15'b000_0001_100_100_0_0);
    end
    for (int i = 0; i < 3; i++) advance();
    n_checks++;
    if (state !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_reset_hold: got state=%0d want 0", state);
    end
    advance();
    n_checks++;
    if (state !== 3'd1 || sec_left !== 4'd5) begin
      n_fail++;
      $display("FAIL mid_reset_restart: got state=%0d sec=%0d want 1/5", state, sec_left);
    end
    for (int i = 0; i < 20; i++) advance();
    n_checks++;
    if (state !== 3'd1 || sec_left !== 4'd5) begin
      n_fail++;
      $display("FAIL mid_reset_pending: got state=%0d sec=%0d want 1/5", state, sec_left);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) car_b = ~car_b;
      ped_req = ($urandom_range(0, 29) == 0);
      RESET   = ($urandom_range(0, 399) == 0);
      advance();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc%0d: got %h want %h", i, obs_vec, exp_vec());
      end
      n_checks++;
      if (lights_a !== 3'b100 && lights_b !== 3'b100) begin
        n_fail++;
        $display("FAIL safety cyc%0d: got la=%b lb=%b want one red", i, lights_a, lights_b);
      end
    end
    RESET   = 1'b0;
    ped_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_green_extension();
    test_car_cycle();
    test_ped_walk();
    test_ped_and_car();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
